// File: rtl/control_unit_if.sv
// Program-memory and datapath-control bus of the control unit.
// master: the control unit itself; slave: memory/datapath side.
interface control_unit_if;
    logic       start;
    logic [2:0] funcao;
    logic [3:0] valor;
    logic [3:0] seletor;
    logic [1:0] a_op;
    logic       b_ld;
    logic       b_clr;
    logic [3:0] imm;
    logic       disp_en;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, funcao, valor,
        output seletor, a_op, b_ld, b_clr, imm, disp_en, busy, done, err
    );

    modport slave (
        output start, funcao, valor,
        input  seletor, a_op, b_ld, b_clr, imm, disp_en, busy, done, err
    );
endinterface

// File: rtl/control_unit.sv
// Control unit: fetches a 3-bit opcode + 4-bit immediate per program address
// and issues one-cycle datapath strobes. Each instruction spends exactly
// three cycles (FETCH, LATCH, EXEC); disp, an illegal opcode or running past
// LAST_PC ends the run in DONE.
module control_unit #(
    parameter logic [3:0] LAST_PC = 4'd15
) (
    input logic           clk,
    input logic           rst,
    control_unit_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_CLRLD = 3'b000;
    localparam logic [2:0] OP_ADDLD = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_DIV2  = 3'b011;
    localparam logic [2:0] OP_DISP  = 3'b100;

    logic [2:0] state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [2:0] op_q, op_d;      // IR opcode field
    logic [3:0] imm_q, imm_d;    // IR immediate field, driven straight to imm
    logic       err_q, err_d;

    logic [1:0] a_op;
    logic       b_ld, b_clr, disp_en;

    // Next-state, PC/IR/err update and EXEC-only strobe decode.
    // Strobes are gated by state so they are zero whenever reset holds IDLE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        imm_d   = imm_q;
        err_d   = err_q;
        a_op    = 2'b00;
        b_ld    = 1'b0;
        b_clr   = 1'b0;
        disp_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d    = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;   // memory settle cycle, seletor stable
            S_LATCH: begin
                op_d    = bus.funcao;
                imm_d   = bus.valor;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_CLRLD: begin a_op = 2'b01; b_clr = 1'b1; end
                    OP_ADDLD: b_ld = 1'b1;
                    OP_ADD:   a_op = 2'b10;
                    OP_DIV2:  a_op = 2'b11;
                    OP_DISP:  disp_en = 1'b1;
                    default:  ;
                endcase
                if (op_q == OP_DISP) begin
                    state_d = S_DONE;
                end else if (op_q > OP_DISP) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (pc_q == LAST_PC) begin
                    // No wrap: running off the end of the program is a fault.
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pc_d    = pc_q + 4'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                // A new run needs start to drop first.
                if (!bus.start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= 4'd0;
            op_q    <= 3'd0;
            imm_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    assign bus.seletor = pc_q;
    assign bus.a_op    = a_op;
    assign bus.b_ld    = b_ld;
    assign bus.b_clr   = b_clr;
    assign bus.disp_en = disp_en;
    assign bus.imm     = imm_q;
    assign bus.busy    = (state_q == S_FETCH) || (state_q == S_LATCH) || (state_q == S_EXEC);
    assign bus.done    = (state_q == S_DONE);
    assign bus.err     = err_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a behavioural program memory answers
// seletor, expected strobes are queued per cycle when a run is started and
// popped as the cycles elapse; cycles without a queued entry expect no strobe.
module tb_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit #(.LAST_PC(4'd15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [2:0] mem_f [16];
    logic [3:0] mem_v [16];
    assign bus.funcao = mem_f[bus.seletor];
    assign bus.valor  = mem_v[bus.seletor];

    typedef struct {
        int         cyc;
        logic [1:0] a_op;
        logic       b_ld;
        logic       b_clr;
        logic       disp_en;
        logic [3:0] imm;
        bit         chk_imm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [1:0] aop, input logic bld, input logic bclr,
                        input logic disp, input logic [3:0] im, input bit ci);
        exp_t e;
        e.cyc = c; e.a_op = aop; e.b_ld = bld; e.b_clr = bclr;
        e.disp_en = disp; e.imm = im; e.chk_imm = ci;
        sb.push_back(e);
    endtask

    // One clock: advance, then sample on the falling edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
        end else begin
            e.cyc = cyc; e.a_op = 2'b00; e.b_ld = 1'b0; e.b_clr = 1'b0;
            e.disp_en = 1'b0; e.imm = 4'd0; e.chk_imm = 1'b0;
        end
        chk($sformatf("a_op@%0d", cyc),    bus.a_op,    e.a_op);
        chk($sformatf("b_ld@%0d", cyc),    bus.b_ld,    e.b_ld);
        chk($sformatf("b_clr@%0d", cyc),   bus.b_clr,   e.b_clr);
        chk($sformatf("disp_en@%0d", cyc), bus.disp_en, e.disp_en);
        if (e.chk_imm) chk($sformatf("imm@%0d", cyc), bus.imm, e.imm);
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 16; i++) begin mem_f[i] = 3'b111; mem_v[i] = 4'd0; end
        mem_f[0] = 3'b000; mem_v[0] = 4'd4;
        mem_f[1] = 3'b001; mem_v[1] = 4'd2;
        mem_f[2] = 3'b010;
        mem_f[3] = 3'b011;
        mem_f[4] = 3'b100;
    endtask

    task automatic push_prog_a();
        push(3,  2'b01, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1);
        push(5,  2'b00, 1'b0, 1'b0, 1'b0, 4'd4, 1'b1);   // imm still held
        push(6,  2'b00, 1'b1, 1'b0, 1'b0, 4'd2, 1'b1);
        push(9,  2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        push(12, 2'b11, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        push(15, 2'b00, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".seletor"}, bus.seletor, 4'd0);
        chk({tag, ".a_op"},    bus.a_op,    2'd0);
        chk({tag, ".b_ld"},    bus.b_ld,    1'b0);
        chk({tag, ".b_clr"},   bus.b_clr,   1'b0);
        chk({tag, ".imm"},     bus.imm,     4'd0);
        chk({tag, ".disp_en"}, bus.disp_en, 1'b0);
        chk({tag, ".busy"},    bus.busy,    1'b0);
        chk({tag, ".done"},    bus.done,    1'b0);
        chk({tag, ".err"},     bus.err,     1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        load_prog_a();

        // Reset state, with the clock running
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        repeat (2) step();
        chk("idle.busy", bus.busy, 1'b0);

        // Program A with a one-cycle start pulse
        push_prog_a();
        bus.start = 1'b1;
        cyc = 0;
        step();
        bus.start = 1'b0;
        chk("a.c1.busy", bus.busy, 1'b1);
        chk("a.c1.seletor", bus.seletor, 4'd0);
        repeat (14) step();
        chk("a.c15.done", bus.done, 1'b0);
        step();
        chk("a.c16.done", bus.done, 1'b1);
        chk("a.c16.busy", bus.busy, 1'b0);
        chk("a.c16.err", bus.err, 1'b0);
        chk("a.sb_empty", sb.size(), 0);
        step();
        chk("a.idle.done", bus.done, 1'b0);

        // Illegal opcode 110 at address 1, start held high through DONE
        mem_f[0] = 3'b000; mem_v[0] = 4'd4;
        mem_f[1] = 3'b110; mem_v[1] = 4'd9;
        push(3, 2'b01, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1);
        bus.start = 1'b1;
        cyc = 0;
        repeat (6) step();
        chk("ill.c6.err", bus.err, 1'b0);
        step();
        chk("ill.c7.err", bus.err, 1'b1);
        chk("ill.c7.done", bus.done, 1'b1);
        chk("ill.c7.seletor", bus.seletor, 4'd1);
        repeat (3) step();
        chk("ill.hold.done", bus.done, 1'b1);
        chk("ill.hold.err", bus.err, 1'b1);
        chk("ill.hold.seletor", bus.seletor, 4'd1);

        // Drop start one cycle, then rerun over an all-add memory
        for (int i = 0; i < 16; i++) begin mem_f[i] = 3'b010; mem_v[i] = 4'd0; end
        bus.start = 1'b0;
        step();
        chk("rst39.idle.done", bus.done, 1'b0);
        chk("rst39.idle.err", bus.err, 1'b1);
        for (int k = 1; k <= 16; k++) push(3 * k, 2'b10, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        bus.start = 1'b1;
        cyc = 0;
        step();
        bus.start = 1'b0;
        chk("rerun.c1.seletor", bus.seletor, 4'd0);
        chk("rerun.c1.err", bus.err, 1'b0);
        chk("rerun.c1.busy", bus.busy, 1'b1);
        repeat (47) step();
        chk("ovr.c48.done", bus.done, 1'b0);
        step();
        chk("ovr.c49.err", bus.err, 1'b1);
        chk("ovr.c49.done", bus.done, 1'b1);
        chk("ovr.c49.seletor", bus.seletor, 4'd15);
        chk("ovr.sb_empty", sb.size(), 0);
        step();

        // Asynchronous reset during LATCH of address 2
        load_prog_a();
        push_prog_a();
        bus.start = 1'b1;
        cyc = 0;
        step();
        bus.start = 1'b0;
        repeat (7) step();
        chk("mid.c8.seletor", bus.seletor, 4'd2);
        #1 rst = 1'b1;
        #1 chk_all_zero("midrst");
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("midrst.held");
        rst = 1'b0;
        repeat (3) step();
        chk("midrst.wait.busy", bus.busy, 1'b0);
        chk("midrst.wait.seletor", bus.seletor, 4'd0);

        // Rerun program A with start toggling while busy
        push_prog_a();
        bus.start = 1'b1;
        cyc = 0;
        step();
        for (int i = 0; i < 15; i++) begin
            bus.start = 1'($urandom_range(0, 1));
            step();
        end
        chk("tog.c16.done", bus.done, 1'b1);
        chk("tog.c16.err", bus.err, 1'b0);
        chk("tog.sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
